// File: rtl/fifo_pkg.sv
// fifo_pkg: shared pointer width default and Gray/binary conversion helpers for the FIFO pointer handlers.
package fifo_pkg;
  localparam int DEF_PTR_WIDTH = 3;
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = '0;
    for (int i = 0; i < 32; i++) b[i] = ^(g >> i);
    return b;
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer bringing a Gray-coded bus into the wclk domain.
module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             wclk,
  input  logic             wrst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] meta;
  always_ff @(posedge wclk) begin
    if (wrst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/wptr_handler.sv
// wptr_handler: FIFO write-side pointer, Gray export, full/almost-full/level flags and sticky overflow.
module wptr_handler
  import fifo_pkg::*;
#(
  parameter int PTR_WIDTH      = DEF_PTR_WIDTH,
  parameter int ALMOST_FULL_TH = 2**PTR_WIDTH - 2
) (
  input  logic                 wclk,
  input  logic                 wrst,
  input  logic                 w_en,
  input  logic [PTR_WIDTH:0]   g_rptr,
  output logic [PTR_WIDTH-1:0] waddr,
  output logic [PTR_WIDTH:0]   b_wptr,
  output logic [PTR_WIDTH:0]   g_wptr,
  output logic                 full,
  output logic                 almost_full,
  output logic [PTR_WIDTH:0]   wlevel,
  output logic                 overflow
);
  localparam int AW = PTR_WIDTH + 1;
  logic [AW-1:0] g_rptr_s, b_wptr_next, g_wptr_next, level_next;
  logic          full_next;
  sync_2ff #(.WIDTH(AW)) u_sync (.wclk(wclk), .wrst(wrst), .d(g_rptr), .q(g_rptr_s));
  assign waddr = b_wptr[PTR_WIDTH-1:0];
  // Full when the next write pointer is one lap ahead of the synced read pointer (top two Gray bits inverted).
  always_comb begin
    b_wptr_next = b_wptr + AW'(w_en & ~full);
    g_wptr_next = AW'(bin2gray(32'(b_wptr_next)));
    full_next   = g_wptr_next == {~g_rptr_s[AW-1:AW-2], g_rptr_s[AW-3:0]};
    level_next  = b_wptr_next - AW'(gray2bin(32'(g_rptr_s)));
  end
  always_ff @(posedge wclk) begin
    if (wrst) begin
      b_wptr      <= '0;
      g_wptr      <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      wlevel      <= '0;
      overflow    <= 1'b0;
    end else begin
      b_wptr      <= b_wptr_next;
      g_wptr      <= g_wptr_next;
      full        <= full_next;
      almost_full <= 32'(level_next) >= ALMOST_FULL_TH;
      wlevel      <= level_next;
      overflow    <= overflow | (w_en & full);
    end
  end
endmodule

// File: doc/wptr_handler.md
WPTR_HANDLER -- requirements
Module: wptr_handler

Interface
REQ-001 The block SHALL have parameter PTR_WIDTH, default 3, giving the address width, with DEPTH = 2**PTR_WIDTH.
REQ-002 The block SHALL have parameter ALMOST_FULL_TH, default DEPTH-2, giving the fill level at which almost_full asserts.
REQ-003 The block SHALL have port wclk, input, 1 bit: the single write-domain clock; all logic is on its rising edge.
REQ-004 The block SHALL have port wrst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port w_en, input, 1 bit: write request from the producer.
REQ-006 The block SHALL have port g_rptr, input, PTR_WIDTH+1 bits: the Gray read pointer from the read domain, asynchronous to wclk.
REQ-007 The block SHALL have port waddr, output, PTR_WIDTH bits: the write address to the memory.
REQ-008 The block SHALL have port b_wptr, output, PTR_WIDTH+1 bits: the binary write pointer.
REQ-009 The block SHALL have port g_wptr, output, PTR_WIDTH+1 bits: the registered Gray write pointer sent to the read domain.
REQ-010 The block SHALL have port full, output, 1 bit: registered full flag.
REQ-011 The block SHALL have port almost_full, output, 1 bit: registered flag, asserted when wlevel >= ALMOST_FULL_TH.
REQ-012 The block SHALL have port wlevel, output, PTR_WIDTH+1 bits: registered fill level as seen from the write domain.
REQ-013 The block SHALL have port overflow, output, 1 bit: sticky flag indicating a write was attempted while full.

Function
REQ-014 A write SHALL be accepted on a wclk edge exactly when w_en=1 and full=0; on acceptance b_wptr increments by 1, modulo 2**(PTR_WIDTH+1).
REQ-015 waddr SHALL equal b_wptr[PTR_WIDTH-1:0], driven directly from the pointer register with no added latency.
REQ-016 g_wptr SHALL be registered as bin2gray(b_wptr_next), so that it is exactly one Gray code step from its previous value and changes on the same edge as b_wptr.
REQ-017 g_rptr SHALL pass through a 2-flop synchronizer on wclk to produce g_rptr_s, which is the only form of g_rptr used internally.
REQ-018 full SHALL be registered with the value (bin2gray(b_wptr_next) == {~g_rptr_s[PTR_WIDTH:PTR_WIDTH-1], g_rptr_s[PTR_WIDTH-2:0]}).
REQ-019 full SHALL assert on the same edge as the write that makes the FIFO hold DEPTH entries.
REQ-020 wlevel SHALL be registered as (b_wptr_next - gray2bin(g_rptr_s)) modulo 2**(PTR_WIDTH+1), with a range of 0..DEPTH.
REQ-021 almost_full SHALL be registered from the same next-state wlevel value, so it updates on the same edge as wlevel.
REQ-022 A change on g_rptr that is stable before edge n SHALL appear in g_rptr_s after edge n+1, and in full, wlevel and almost_full after edge n+2.
REQ-023 On a write attempt while full (w_en=1, full=1), b_wptr, waddr and g_wptr SHALL hold and overflow SHALL set to 1.
REQ-024 overflow SHALL stay set until wrst.
REQ-025 If a read frees space on the same edge as a blocked write, the write SHALL remain blocked; there is no look-ahead past the registered full.
REQ-026 Pointer wrap SHALL occur without any special case: 2**(PTR_WIDTH+1)-1 increments to 0.

Reset
REQ-027 When wrst=1 at a wclk edge, b_wptr, g_wptr, waddr, wlevel, the synchronizer flops, full, almost_full and overflow SHALL all be 0, regardless of w_en.
REQ-028 A reset mid-operation SHALL discard the accepted-write count; the first write after wrst falls SHALL use waddr=0.

Structure
REQ-029 Package fifo_pkg SHALL hold the bin2gray and gray2bin functions and the default PTR_WIDTH, shared with the read-pointer handler.
REQ-030 The block SHALL instantiate one sub-module, sync_2ff (parameterised width, wclk, wrst), for the g_rptr synchronizer.

Verification
REQ-031 Reset, g_rptr=0, w_en=1 for 8 cycles -> waddr 0..7, full=1 after 8th write, g_wptr=4'b1100, wlevel=8.
REQ-032 From full, w_en=1 for 2 cycles -> b_wptr stays 8, overflow=1, and overflow stays 1 after w_en=0.
REQ-033 From full, set g_rptr=4'b0001 -> full=0 and wlevel=7 exactly 3 edges later, and not earlier.
REQ-034 With ALMOST_FULL_TH=6, write 6 entries with g_rptr=0 -> almost_full=1 on the 6th write edge and 0 after the 5th.
REQ-035 Write 15 entries while g_rptr tracks 7 behind, then write once more -> b_wptr wraps 15->0, g_wptr 4'b1000->4'b0000, and full is never set.
REQ-036 Hold w_en=1, assert wrst for 1 cycle mid-stream -> every output is 0 on that edge, and the next accepted write uses waddr=0.
